// File: rtl/keypad_pkg.sv
// Shared definitions for the keypad BCD entry block: key codes, keypad map,
// FSM encoding and one shift/subtract-3 step of the BCD-to-binary converter.
package keypad_pkg;

    typedef logic [4:0] key_code_t;

    localparam key_code_t KEY_0     = 5'd0;
    localparam key_code_t KEY_1     = 5'd1;
    localparam key_code_t KEY_2     = 5'd2;
    localparam key_code_t KEY_3     = 5'd3;
    localparam key_code_t KEY_4     = 5'd4;
    localparam key_code_t KEY_5     = 5'd5;
    localparam key_code_t KEY_6     = 5'd6;
    localparam key_code_t KEY_7     = 5'd7;
    localparam key_code_t KEY_8     = 5'd8;
    localparam key_code_t KEY_9     = 5'd9;
    localparam key_code_t KEY_STAR  = 5'd10;
    localparam key_code_t KEY_HASH  = 5'd11;
    localparam key_code_t KEY_A     = 5'd12;
    localparam key_code_t KEY_B     = 5'd13;
    localparam key_code_t KEY_C     = 5'd14;
    localparam key_code_t KEY_D     = 5'd15;
    localparam key_code_t KEY_NONE  = 5'd16;
    localparam key_code_t KEY_MULTI = 5'd17;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_CONV = 2'd1,
        ST_HOLD = 2'd2
    } state_t;

    // Keypad map, index = row*4 + col.
    function automatic key_code_t key_lookup(input logic [3:0] idx);
        case (idx)
            4'd0:    key_lookup = KEY_1;
            4'd1:    key_lookup = KEY_2;
            4'd2:    key_lookup = KEY_3;
            4'd3:    key_lookup = KEY_A;
            4'd4:    key_lookup = KEY_4;
            4'd5:    key_lookup = KEY_5;
            4'd6:    key_lookup = KEY_6;
            4'd7:    key_lookup = KEY_B;
            4'd8:    key_lookup = KEY_7;
            4'd9:    key_lookup = KEY_8;
            4'd10:   key_lookup = KEY_9;
            4'd11:   key_lookup = KEY_C;
            4'd12:   key_lookup = KEY_STAR;
            4'd13:   key_lookup = KEY_0;
            4'd14:   key_lookup = KEY_HASH;
            4'd15:   key_lookup = KEY_D;
            default: key_lookup = KEY_NONE;
        endcase
    endfunction

    // Shift {bcd, bin} right one place, then pull 3 from any BCD nibble >= 8.
    function automatic logic [23:0] conv_step(input logic [23:0] r);
        logic [23:0] t;
        t = r >> 1;
        for (int i = 0; i < 3; i++) begin
            if (t[12 + 4*i + 3])
                t[12 + 4*i +: 4] = t[12 + 4*i +: 4] - 4'd3;
        end
        return t;
    endfunction

endpackage

// File: rtl/keypad_scan.sv
// Keypad column scanner: row synchronizer, column stepping, per-frame decode
// into a single key / NONE / MULTI, and frame-count debounce with press events.
module keypad_scan
    import keypad_pkg::*;
#(
    parameter int SCAN_DIV       = 50000,
    parameter int DEBOUNCE_SCANS = 4
) (
    input  logic      clk_in,
    input  logic      rst_n,
    input  logic [3:0] row_in,
    output logic [3:0] col_out,
    output logic      key_evt,
    output key_code_t key_code
);

    localparam int DIV_W = $clog2(SCAN_DIV + 1);
    localparam int DB_W  = $clog2(DEBOUNCE_SCANS + 1);

    logic [3:0]       row_meta, row_sync;
    logic [DIV_W-1:0] div_cnt;
    logic [1:0]       col_idx;
    logic [1:0]       hits_acc;     // keys seen this frame: 0, 1, 2 = two or more
    key_code_t        code_acc;
    key_code_t        cand, stable;
    logic [DB_W-1:0]  cand_cnt;

    logic            sample;
    logic [3:0]      down;
    logic [2:0]      col_hits;
    logic [1:0]      row_hit;
    logic [1:0]      hits_nxt;
    key_code_t       code_nxt, frame_res;
    logic [DB_W-1:0] cnt_nxt;
    logic            accept;

    assign sample  = (div_cnt == DIV_W'(SCAN_DIV - 1));
    assign down    = ~row_sync;
    assign col_out = ~(4'b0001 << col_idx);

    always_comb begin
        col_hits = '0;
        row_hit  = '0;
        for (int r = 0; r < 4; r++) begin
            if (down[r]) begin
                col_hits = col_hits + 3'd1;
                row_hit  = 2'(r);
            end
        end
        hits_nxt = hits_acc;
        code_nxt = code_acc;
        if (col_hits != 3'd0) begin
            if (hits_acc == 2'd0 && col_hits == 3'd1) begin
                hits_nxt = 2'd1;
                code_nxt = key_lookup({row_hit, col_idx});
            end else begin
                hits_nxt = 2'd2;
            end
        end
        frame_res = KEY_NONE;
        if (hits_nxt == 2'd1)
            frame_res = code_nxt;
        else if (hits_nxt == 2'd2)
            frame_res = KEY_MULTI;
        if (frame_res == cand)
            cnt_nxt = (cand_cnt == DB_W'(DEBOUNCE_SCANS)) ? cand_cnt : cand_cnt + DB_W'(1);
        else
            cnt_nxt = DB_W'(1);
        accept = (cnt_nxt == DB_W'(DEBOUNCE_SCANS)) && (frame_res != stable);
    end

    always_ff @(posedge clk_in or negedge rst_n) begin
        if (!rst_n) begin
            row_meta <= 4'hF;
            row_sync <= 4'hF;
            div_cnt  <= '0;
            col_idx  <= '0;
            hits_acc <= '0;
            code_acc <= KEY_NONE;
            cand     <= KEY_NONE;
            cand_cnt <= '0;
            stable   <= KEY_NONE;
            key_evt  <= 1'b0;
            key_code <= KEY_NONE;
        end else begin
            row_meta <= row_in;
            row_sync <= row_meta;
            key_evt  <= 1'b0;
            if (!sample) begin
                div_cnt <= div_cnt + DIV_W'(1);
            end else begin
                div_cnt <= '0;
                col_idx <= col_idx + 2'd1;
                if (col_idx != 2'd3) begin
                    hits_acc <= hits_nxt;
                    code_acc <= code_nxt;
                end else begin
                    hits_acc <= '0;
                    code_acc <= KEY_NONE;
                    cand     <= frame_res;
                    cand_cnt <= cnt_nxt;
                    if (accept) begin
                        stable <= frame_res;
                        // Only a NONE -> single key transition is a press event.
                        if (stable == KEY_NONE && !frame_res[4]) begin
                            key_evt  <= 1'b1;
                            key_code <= frame_res;
                        end
                    end
                end
            end
        end
    end

endmodule

// File: rtl/keypad_bcd_entry.sv
// Keypad operand entry: accumulates up to three BCD digits, converts them to
// binary with a 12-step shift/subtract-3 loop, and offers the result via valid/ready.
module keypad_bcd_entry
    import keypad_pkg::*;
#(
    parameter int SCAN_DIV       = 50000,
    parameter int DEBOUNCE_SCANS = 4
) (
    input  logic        clk_in,
    input  logic        rst_n,
    input  logic [3:0]  row_in,
    output logic [3:0]  col_out,
    output logic [11:0] digits_out,
    output logic [11:0] bin_out,
    output logic        bin_valid,
    input  logic        bin_ready,
    output logic        busy
);

    logic      key_evt;
    key_code_t key_code;

    keypad_scan #(
        .SCAN_DIV       (SCAN_DIV),
        .DEBOUNCE_SCANS (DEBOUNCE_SCANS)
    ) u_scan (
        .clk_in   (clk_in),
        .rst_n    (rst_n),
        .row_in   (row_in),
        .col_out  (col_out),
        .key_evt  (key_evt),
        .key_code (key_code)
    );

    state_t      state, state_nxt;
    logic [1:0]  count, count_nxt;
    logic [11:0] digits_nxt, bin_nxt;
    logic [23:0] sr, sr_nxt, sr_step;
    logic [3:0]  iter, iter_nxt;

    assign sr_step = conv_step(sr);

    always_ff @(posedge clk_in or negedge rst_n) begin
        if (!rst_n) begin
            state      <= ST_IDLE;
            count      <= '0;
            digits_out <= '0;
            bin_out    <= '0;
            sr         <= '0;
            iter       <= '0;
        end else begin
            state      <= state_nxt;
            count      <= count_nxt;
            digits_out <= digits_nxt;
            bin_out    <= bin_nxt;
            sr         <= sr_nxt;
            iter       <= iter_nxt;
        end
    end

    always_comb begin
        state_nxt  = state;
        count_nxt  = count;
        digits_nxt = digits_out;
        bin_nxt    = bin_out;
        sr_nxt     = sr;
        iter_nxt   = iter;
        bin_valid  = 1'b0;
        busy       = 1'b0;
        case (state)
            ST_IDLE: begin
                if (key_evt) begin
                    if (key_code <= KEY_9) begin
                        if (count != 2'd3) begin
                            digits_nxt = {digits_out[7:0], key_code[3:0]};
                            count_nxt  = count + 2'd1;
                        end
                    end else if (key_code == KEY_STAR) begin
                        digits_nxt = '0;
                        count_nxt  = '0;
                    end else if (key_code == KEY_HASH && count != 2'd0) begin
                        sr_nxt    = {digits_out, 12'h000};
                        iter_nxt  = '0;
                        state_nxt = ST_CONV;
                    end
                end
            end
            ST_CONV: begin
                busy     = 1'b1;
                sr_nxt   = sr_step;
                iter_nxt = iter + 4'd1;
                if (iter == 4'd11) begin
                    bin_nxt   = sr_step[11:0];
                    state_nxt = ST_HOLD;
                end
            end
            ST_HOLD: begin
                busy      = 1'b1;
                bin_valid = 1'b1;
                if (bin_ready) begin
                    digits_nxt = '0;
                    count_nxt  = '0;
                    state_nxt  = ST_IDLE;
                end
            end
            default: state_nxt = ST_IDLE;
        endcase
    end

endmodule

// File: tb/tb_keypad_bcd_entry.sv
// Directed bench for keypad_bcd_entry with a press/release keypad model and a
// scoreboard of expected operands checked at each valid/ready handshake.
module tb_keypad_bcd_entry;

    localparam int K1 = 0, K2 = 1, K3 = 2, K4 = 4, K5 = 5, K6 = 6;
    localparam int K7 = 8, K8 = 9, K9 = 10, KS = 12, K0 = 13, KH = 14;

    logic        clk_in = 1'b0;
    logic        rst_n;
    logic [3:0]  row_in;
    logic [3:0]  col_out;
    logic [11:0] digits_out;
    logic [11:0] bin_out;
    logic        bin_valid;
    logic        bin_ready;
    logic        busy;

    logic [15:0] pressed;
    int          tests = 0;
    int          fails = 0;
    int          exp_q[$];
    int          valid_rises = 0;
    int          exp_rises = 0;

    always #5 clk_in = ~clk_in;

    keypad_bcd_entry #(
        .SCAN_DIV       (4),
        .DEBOUNCE_SCANS (2)
    ) dut (
        .clk_in     (clk_in),
        .rst_n      (rst_n),
        .row_in     (row_in),
        .col_out    (col_out),
        .digits_out (digits_out),
        .bin_out    (bin_out),
        .bin_valid  (bin_valid),
        .bin_ready  (bin_ready),
        .busy       (busy)
    );

    // A pressed key shorts its row low while its column is driven low.
    always_comb begin
        for (int r = 0; r < 4; r++) begin
            row_in[r] = 1'b1;
            for (int c = 0; c < 4; c++)
                if (pressed[r*4 + c] && !col_out[c]) row_in[r] = 1'b0;
        end
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0d (0x%0h) expected %0d (0x%0h)", tag, obs, obs, exp, exp);
        end
    endtask

    // Output side: latency from busy to valid, handshake value, drop after handshake.
    int   cyc = 0;
    int   t_busy = 0;
    logic prev_busy = 1'b0, prev_valid = 1'b0, hs_pend = 1'b0;

    always @(negedge clk_in) begin
        cyc++;
        if (hs_pend) begin
            check("valid_drop", 32'(bin_valid), 32'd0);
            check("digits_clr", 32'(digits_out), 32'd0);
        end
        hs_pend = 1'b0;
        if (busy && !prev_busy) t_busy = cyc;
        if (bin_valid && !prev_valid) begin
            valid_rises++;
            check("valid_lat", 32'(cyc - t_busy), 32'd12);
        end
        if (bin_valid && bin_ready) begin
            check("sb_nonempty", 32'(exp_q.size() > 0), 32'd1);
            if (exp_q.size() > 0) check("bin_out", 32'(bin_out), 32'(exp_q.pop_front()));
            hs_pend = 1'b1;
        end
        prev_busy  = busy;
        prev_valid = bin_valid;
    end

    task automatic cyc_wait(input int n);
        repeat (n) @(posedge clk_in);
        #2;
    endtask

    task automatic press(input int idx, input int hold);
        pressed[idx] = 1'b1;
        cyc_wait(hold);
        pressed[idx] = 1'b0;
        cyc_wait(64);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        pressed   = '0;
        bin_ready = 1'b1;
        rst_n     = 1'b0;
        cyc_wait(3);
        check("rst_col", 32'(col_out), 32'h0000_000E);
        check("rst_digits", 32'(digits_out), 32'd0);
        check("rst_bin", 32'(bin_out), 32'd0);
        check("rst_valid", 32'(bin_valid), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        rst_n = 1'b1;
        cyc_wait(40);

        // 1, 2, 3, #
        press(K1, 64);
        press(K2, 64);
        press(K3, 64);
        check("digits_123", 32'(digits_out), 32'h123);
        exp_q.push_back(123);
        exp_rises++;
        press(KH, 64);
        check("rises_123", 32'(valid_rises), 32'(exp_rises));
        check("idle_123", 32'(busy), 32'd0);

        // 9, 9, 9, 9, # : fourth digit dropped
        for (int i = 0; i < 4; i++) press(K9, 64);
        check("digits_999", 32'(digits_out), 32'h999);
        exp_q.push_back(999);
        exp_rises++;
        press(KH, 64);
        check("rises_999", 32'(valid_rises), 32'(exp_rises));

        // 5, *, 7, # then # alone
        press(K5, 64);
        check("digits_5", 32'(digits_out), 32'h005);
        press(KS, 64);
        check("digits_star", 32'(digits_out), 32'd0);
        press(K7, 64);
        exp_q.push_back(7);
        exp_rises++;
        press(KH, 64);
        check("rises_7", 32'(valid_rises), 32'(exp_rises));
        press(KH, 64);
        check("hash_empty", 32'(valid_rises), 32'(exp_rises));
        check("hash_empty_busy", 32'(busy), 32'd0);

        // 4, 2, # with consumer stalled; 8 pressed during HOLD
        bin_ready = 1'b0;
        press(K4, 64);
        press(K2, 64);
        exp_q.push_back(42);
        exp_rises++;
        press(KH, 64);
        check("hold_valid", 32'(bin_valid), 32'd1);
        check("hold_bin", 32'(bin_out), 32'd42);
        press(K8, 64);
        check("hold_valid2", 32'(bin_valid), 32'd1);
        check("hold_bin2", 32'(bin_out), 32'd42);
        check("hold_digits", 32'(digits_out), 32'h042);
        bin_ready = 1'b1;
        cyc_wait(3);
        check("post_hs_valid", 32'(bin_valid), 32'd0);
        check("post_hs_digits", 32'(digits_out), 32'd0);
        check("rises_42", 32'(valid_rises), 32'(exp_rises));

        // Debounce: one-frame tap, two-key chord, long hold
        press(K6, 16);
        check("tap_no_evt", 32'(digits_out), 32'd0);
        pressed[K1] = 1'b1;
        pressed[K2] = 1'b1;
        cyc_wait(80);
        pressed = '0;
        cyc_wait(64);
        check("multi_no_evt", 32'(digits_out), 32'd0);
        press(K5, 160);
        check("long_one_evt", 32'(digits_out), 32'h005);

        // Reset in the middle of a conversion
        press(KS, 64);
        check("star_clear", 32'(digits_out), 32'd0);
        press(K5, 64);
        check("digits_5b", 32'(digits_out), 32'h005);
        pressed[KH] = 1'b1;
        n = 0;
        while (!busy && n < 200) begin
            cyc_wait(1);
            n++;
        end
        check("busy_seen", 32'(busy), 32'd1);
        cyc_wait(5);
        rst_n = 1'b0;
        #1;
        check("abort_col", 32'(col_out), 32'h0000_000E);
        check("abort_digits", 32'(digits_out), 32'd0);
        check("abort_bin", 32'(bin_out), 32'd0);
        check("abort_valid", 32'(bin_valid), 32'd0);
        check("abort_busy", 32'(busy), 32'd0);
        pressed = '0;
        cyc_wait(3);
        rst_n = 1'b1;
        cyc_wait(40);
        check("abort_rises", 32'(valid_rises), 32'(exp_rises));

        press(K3, 64);
        check("digits_3", 32'(digits_out), 32'h003);
        exp_q.push_back(3);
        exp_rises++;
        press(KH, 64);
        check("rises_3", 32'(valid_rises), 32'(exp_rises));
        check("sb_empty", 32'(exp_q.size()), 32'd0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
